vehicle_sensor_queue: RTL and testbench

//  Producer side of the traffic controller's sensor-X input. Conditions the raw

---
 rtl/vehicle_sensor_queue_if.sv | 10 +
 rtl/vehicle_sensor_queue.sv | 68 ++++++
 tb/tb_vehicle_sensor_queue.sv | 148 ++++++++++++++
 3 files changed

// File: rtl/vehicle_sensor_queue_if.sv
// vehicle_sensor_queue_if: sensor inputs and queue status between the switch conditioner and the controller
interface vehicle_sensor_queue_if;
    logic       raw_sensor;
    logic       served;
    logic       x;
    logic [2:0] queue;
    logic [1:0] state;
    modport master (output raw_sensor, served, input x, queue, state);
    modport slave (input raw_sensor, served, output x, queue, state);
endinterface

// File: rtl/vehicle_sensor_queue.sv
// vehicle_sensor_queue: debounces the vehicle switch, queues arrivals and retires them during green
module vehicle_sensor_queue #(
    parameter int DEBOUNCE_CYCLES = 1_000_000,
    parameter int SERVE_CYCLES    = 50_000_000,
    parameter int MAX_QUEUE       = 7
) (
    input logic                     CLOCK_50,
    input logic                     reset,
    vehicle_sensor_queue_if.slave   bus
);
    localparam int DW = DEBOUNCE_CYCLES > 1 ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam int SW = SERVE_CYCLES > 1 ? $clog2(SERVE_CYCLES) : 1;
    typedef enum logic [1:0] {IDLE = 2'b00, WAITING = 2'b01, SERVING = 2'b10} state_t;
    logic          s1, s2, clean, clean_d;
    logic [DW-1:0] db_cnt;
    logic [SW-1:0] sv_cnt;
    logic [2:0]    queue_q, next_queue;
    logic          x_q;
    state_t        state_q;
    logic          arrival, departure, serving;
    assign arrival   = clean & ~clean_d;
    assign serving   = bus.served && queue_q != 3'd0;
    assign departure = serving && sv_cnt == SW'(SERVE_CYCLES - 1);
    // arrival+departure cancel before saturation is considered, so a full queue never drops
    always_comb
        next_queue = (arrival && !departure) ? (queue_q == 3'(MAX_QUEUE) ? queue_q : queue_q + 3'd1) :
                     (departure && !arrival) ? queue_q - 3'd1 : queue_q;
    // two-flop synchronizer and debounced level with its edge-detect history
    always_ff @(posedge CLOCK_50 or negedge reset)
        if (!reset) begin
            s1      <= 1'b0;
            s2      <= 1'b0;
            clean   <= 1'b0;
            clean_d <= 1'b0;
            db_cnt  <= '0;
        end else begin
            s1      <= bus.raw_sensor;
            s2      <= s1;
            clean_d <= clean;
            if (s2 == clean)
                db_cnt <= '0;
            else if (db_cnt == DW'(DEBOUNCE_CYCLES - 1)) begin
                clean  <= s2;
                db_cnt <= '0;
            end else
                db_cnt <= db_cnt + 1'b1;
        end
    // green-time accumulator; partial green is discarded whenever green drops or the queue empties
    always_ff @(posedge CLOCK_50 or negedge reset)
        if (!reset)
            sv_cnt <= '0;
        else
            sv_cnt <= (!serving || departure) ? '0 : sv_cnt + 1'b1;
    // queue count, x and FSM state all follow the next queue value on the same edge
    always_ff @(posedge CLOCK_50 or negedge reset)
        if (!reset) begin
            queue_q <= 3'd0;
            x_q     <= 1'b0;
            state_q <= IDLE;
        end else begin
            queue_q <= next_queue;
            x_q     <= next_queue != 3'd0;
            state_q <= next_queue == 3'd0 ? IDLE : bus.served ? SERVING : WAITING;
        end
    assign bus.queue = queue_q;
    assign bus.x     = x_q;
    assign bus.state = state_q;
endmodule

// File: tb/tb_vehicle_sensor_queue.sv
// tb_vehicle_sensor_queue: directed checks of debounce, counting, saturation and serving
module tb_vehicle_sensor_queue;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_chk = 0;
    int   n_pass = 0;
    vehicle_sensor_queue_if bus ();
    vehicle_sensor_queue #(.DEBOUNCE_CYCLES(4), .SERVE_CYCLES(8), .MAX_QUEUE(7)) dut (
        .CLOCK_50 (clk),
        .reset    (rst_n),
        .bus      (bus)
    );
    always #5 clk = ~clk;
    task automatic check(input string tag, input int got, input int exp);
        n_chk++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask
    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask
    task automatic do_reset();
        rst_n = 1'b0;
        bus.raw_sensor = 1'b0;
        bus.served = 1'b0;
        tick(2);
        rst_n = 1'b1;
        tick(1);
    endtask
    task automatic press();
        bus.raw_sensor = 1'b1;
        tick(6);
        bus.raw_sensor = 1'b0;
        tick(6);
    endtask
    initial begin
        int e;
        // 1: reset with switch held and green on
        bus.raw_sensor = 1'b1;
        bus.served = 1'b1;
        #2;
        check("rst_x", int'(bus.x), 0);
        check("rst_queue", int'(bus.queue), 0);
        check("rst_state", int'(bus.state), 0);
        tick(2);
        rst_n = 1'b1;
        e = 0;
        while (!bus.x && e < 7) begin
            tick(1);
            e++;
        end
        check("t1_x_within_7", int'(bus.x), 1);
        check("t1_queue", int'(bus.queue), 1);
        check("t1_state_serving", int'(bus.state), 2);
        bus.served = 1'b0;
        tick(1);
        check("t1_state_waiting", int'(bus.state), 1);
        tick(10);
        check("t1_held_once", int'(bus.queue), 1);
        // 2: bounce shorter than the debounce window
        do_reset();
        repeat (5) begin
            bus.raw_sensor = 1'b1;
            tick(3);
            bus.raw_sensor = 1'b0;
            tick(2);
        end
        tick(10);
        check("t2_queue", int'(bus.queue), 0);
        check("t2_x", int'(bus.x), 0);
        check("t2_state", int'(bus.state), 0);
        // 3: count up and saturate
        do_reset();
        for (int k = 1; k <= 9; k++) begin
            press();
            check($sformatf("t3_queue_%0d", k), int'(bus.queue), k > 7 ? 7 : k);
        end
        check("t3_x", int'(bus.x), 1);
        check("t3_state", int'(bus.state), 1);
        // 4: serve three vehicles
        do_reset();
        repeat (3) press();
        check("t4_queue_start", int'(bus.queue), 3);
        bus.served = 1'b1;
        tick(1);
        check("t4_state_serving", int'(bus.state), 2);
        tick(6);
        check("t4_queue_hold", int'(bus.queue), 3);
        tick(1);
        check("t4_queue_2", int'(bus.queue), 2);
        tick(8);
        check("t4_queue_1", int'(bus.queue), 1);
        tick(7);
        check("t4_queue_1_hold", int'(bus.queue), 1);
        check("t4_x_hold", int'(bus.x), 1);
        tick(1);
        check("t4_queue_0", int'(bus.queue), 0);
        check("t4_x_0", int'(bus.x), 0);
        check("t4_state_idle", int'(bus.state), 0);
        bus.served = 1'b0;
        // 5: interrupted green does not carry over
        do_reset();
        repeat (2) press();
        bus.served = 1'b1;
        tick(5);
        check("t5_q_after_5", int'(bus.queue), 2);
        bus.served = 1'b0;
        tick(3);
        check("t5_q_gap", int'(bus.queue), 2);
        check("t5_state_gap", int'(bus.state), 1);
        bus.served = 1'b1;
        tick(7);
        check("t5_q_after_7", int'(bus.queue), 2);
        tick(1);
        check("t5_q_after_8", int'(bus.queue), 1);
        bus.served = 1'b0;
        tick(2);
        check("t5_q_final", int'(bus.queue), 1);
        // 6: arrival and departure on the same edge at 4 and at 7
        do_reset();
        repeat (4) press();
        check("t6_q4_start", int'(bus.queue), 4);
        bus.served = 1'b1;
        tick(1);
        bus.raw_sensor = 1'b1;
        tick(7);
        bus.served = 1'b0;
        check("t6_q4_same", int'(bus.queue), 4);
        bus.raw_sensor = 1'b0;
        tick(8);
        check("t6_q4_after", int'(bus.queue), 4);
        do_reset();
        repeat (7) press();
        check("t6_q7_start", int'(bus.queue), 7);
        bus.served = 1'b1;
        tick(1);
        bus.raw_sensor = 1'b1;
        tick(7);
        bus.served = 1'b0;
        check("t6_q7_same", int'(bus.queue), 7);
        check("t6_x", int'(bus.x), 1);
        bus.raw_sensor = 1'b0;
        tick(8);
        check("t6_q7_after", int'(bus.queue), 7);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
